// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state encoding, transaction codes and default parameters for the ATM block
package atm_pkg;

  localparam int PIN_DIGITS_DEF   = 4;
  localparam int MAX_TRIES_DEF    = 3;
  localparam int NUM_ACCOUNTS_DEF = 4;
  localparam int BAL_W_DEF        = 64;
  localparam int AMT_W_DEF        = 32;
  localparam int TIMEOUT_CYC_DEF  = 1000;
  localparam int WD_LIMIT_DEF     = 50000;
  localparam int INIT_BAL_DEF     = 100000;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PIN_ENTRY = 4'd1,
    ST_PIN_CHECK = 4'd2,
    ST_MENU      = 4'd3,
    ST_DEPOSIT   = 4'd4,
    ST_WITHDRAW  = 4'd5,
    ST_INQUIRY   = 4'd6,
    ST_DONE      = 4'd7,
    ST_BLOCKED   = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    TR_DEPOSIT  = 2'b00,
    TR_WITHDRAW = 2'b01,
    TR_INQUIRY  = 2'b10,
    TR_END      = 2'b11
  } trans_t;

endpackage

// File: rtl/atm_pin_entry.sv
// rtl/atm_pin_entry.sv - PIN digit collector and comparator
// Purpose: shifts BCD digits in MSB-first, counts them, and flags a match
//          against the reference PIN.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   i_clear           discard collected digits and count
//   i_enable          accept digit strobes (PIN_ENTRY only)
//   i_digit_stb/i_digit  digit strobe and value
//   i_pin_ref         reference PIN, first digit in the MSBs
//   o_full            PIN_DIGITS digits collected
//   o_match           collected digits equal i_pin_ref
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = PIN_DIGITS_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_enable,
  input  logic                    i_digit_stb,
  input  logic [3:0]              i_digit,
  input  logic [4*PIN_DIGITS-1:0] i_pin_ref,
  output logic                    o_full,
  output logic                    o_match
);

  localparam int CNT_W = $clog2(PIN_DIGITS + 1);

  logic [4*PIN_DIGITS-1:0] r_shift;
  logic [CNT_W-1:0]        r_cnt;

  always_ff @(posedge clock) begin
    if (!reset || i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_enable && i_digit_stb && !o_full) begin
      r_shift <= {r_shift[4*PIN_DIGITS-5:0], i_digit};
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_full  = (r_cnt == CNT_W'(PIN_DIGITS));
  assign o_match = (r_shift == i_pin_ref);

endmodule

// File: rtl/atm_multi_account.sv
// rtl/atm_multi_account.sv - multi-account ATM session controller
// Purpose: card/PIN session FSM with per-account balances and blocked flags,
//          deposit/withdraw/inquiry handling, session withdrawal limit and
//          idle timeout. All outputs are registered.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-low reset
//   card_present, account_id     card level and account sampled on insertion
//   pin_ref, digit_stb, digit    reference PIN and digit input
//   trans_stb, trans_type        transaction select (atm_pkg::trans_t)
//   amount_stb, amount           amount input
//   balance_updated, give_money, insufficient_funds, limit_exceeded,
//   timeout, balance_valid       one-cycle pulses
//   incorrect_pin, warning, block  PIN status levels
//   balance_out                  last inquiry result
module atm_multi_account
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS   = PIN_DIGITS_DEF,
  parameter int MAX_TRIES    = MAX_TRIES_DEF,
  parameter int NUM_ACCOUNTS = NUM_ACCOUNTS_DEF,
  parameter int BAL_W        = BAL_W_DEF,
  parameter int AMT_W        = AMT_W_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int WD_LIMIT     = WD_LIMIT_DEF,
  parameter int INIT_BAL     = INIT_BAL_DEF,
  localparam int ID_W        = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    card_present,
  input  logic [ID_W-1:0]         account_id,
  input  logic [4*PIN_DIGITS-1:0] pin_ref,
  input  logic                    digit_stb,
  input  logic [3:0]              digit,
  input  logic                    trans_stb,
  input  logic [1:0]              trans_type,
  input  logic                    amount_stb,
  input  logic [AMT_W-1:0]        amount,
  output logic                    balance_updated,
  output logic                    give_money,
  output logic                    incorrect_pin,
  output logic                    warning,
  output logic                    block,
  output logic                    insufficient_funds,
  output logic                    limit_exceeded,
  output logic                    timeout,
  output logic [BAL_W-1:0]        balance_out,
  output logic                    balance_valid
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int SUM_W   = BAL_W + 1;

  state_t r_state, w_state_nx;

  logic [BAL_W-1:0]        r_bal [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] r_blocked;
  logic [ID_W-1:0]         r_acct, w_acct_nx;
  logic [TRIES_W-1:0]      r_tries, w_tries_nx;
  logic [BAL_W-1:0]        r_sess, w_sess_nx;
  logic [TMO_W-1:0]        r_tmo;

  logic r_incorrect, r_warning, r_block;
  logic r_bu, r_gm, r_if, r_le, r_to, r_bv;
  logic [BAL_W-1:0] r_bal_out;

  logic w_incorrect_nx, w_warning_nx, w_block_nx;
  logic w_bu_nx, w_gm_nx, w_if_nx, w_le_nx, w_to_nx, w_bv_nx;
  logic [BAL_W-1:0] w_bal_out_nx;
  logic             w_bal_we, w_set_blk;
  logic [BAL_W-1:0] w_bal_wdata;

  logic w_pin_full, w_pin_match;

  atm_pin_entry #(.PIN_DIGITS(PIN_DIGITS)) u_pin (
    .clock       (clock),
    .reset       (reset),
    .i_clear     ((r_state == ST_IDLE) || (r_state == ST_PIN_CHECK)),
    .i_enable    (r_state == ST_PIN_ENTRY),
    .i_digit_stb (digit_stb),
    .i_digit     (digit),
    .i_pin_ref   (pin_ref),
    .o_full      (w_pin_full),
    .o_match     (w_pin_match)
  );

  // Arithmetic is done one bit wider than the balance so deposit overflow
  // and the session-limit compare cannot wrap.
  logic [BAL_W-1:0] w_sel_bal;
  logic [SUM_W-1:0] w_amt_ext, w_dep_sum, w_wd_total;
  logic             w_short, w_over_limit;

  assign w_sel_bal    = r_bal[r_acct];
  assign w_amt_ext    = SUM_W'(amount);
  assign w_dep_sum    = {1'b0, w_sel_bal} + w_amt_ext;
  assign w_wd_total   = {1'b0, r_sess} + w_amt_ext;
  assign w_short      = w_amt_ext > {1'b0, w_sel_bal};
  assign w_over_limit = w_wd_total > SUM_W'(WD_LIMIT);

  logic w_waiting, w_any_stb, w_tmo_hit;
  assign w_waiting = (r_state == ST_PIN_ENTRY) || (r_state == ST_MENU) ||
                     (r_state == ST_DEPOSIT)   || (r_state == ST_WITHDRAW);
  assign w_any_stb = digit_stb || trans_stb || amount_stb;
  assign w_tmo_hit = w_waiting && !w_any_stb && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx     = r_state;
    w_incorrect_nx = r_incorrect;
    w_warning_nx   = r_warning;
    w_block_nx     = r_block;
    w_bu_nx        = 1'b0;
    w_gm_nx        = 1'b0;
    w_if_nx        = 1'b0;
    w_le_nx        = 1'b0;
    w_to_nx        = 1'b0;
    w_bv_nx        = 1'b0;
    w_bal_out_nx   = r_bal_out;
    w_bal_we       = 1'b0;
    w_bal_wdata    = w_sel_bal;
    w_set_blk      = 1'b0;
    w_acct_nx      = r_acct;
    w_tries_nx     = r_tries;
    w_sess_nx      = r_sess;

    if (!card_present) begin
      // Card removal aborts whatever is in progress, including a strobe
      // arriving in the same cycle.
      w_state_nx     = ST_IDLE;
      w_incorrect_nx = 1'b0;
      w_warning_nx   = 1'b0;
      w_block_nx     = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_acct_nx  = account_id;
          w_tries_nx = '0;
          w_sess_nx  = '0;
          if (r_blocked[account_id]) begin
            w_state_nx = ST_BLOCKED;
            w_block_nx = 1'b1;
          end else begin
            w_state_nx = ST_PIN_ENTRY;
          end
        end
        ST_PIN_ENTRY: if (w_pin_full) w_state_nx = ST_PIN_CHECK;
        ST_PIN_CHECK: begin
          if (w_pin_match) begin
            w_state_nx     = ST_MENU;
            w_incorrect_nx = 1'b0;
            w_warning_nx   = 1'b0;
          end else begin
            w_tries_nx     = r_tries + TRIES_W'(1);
            w_incorrect_nx = 1'b1;
            if (w_tries_nx == TRIES_W'(MAX_TRIES - 1)) w_warning_nx = 1'b1;
            if (w_tries_nx == TRIES_W'(MAX_TRIES)) begin
              w_set_blk  = 1'b1;
              w_block_nx = 1'b1;
              w_state_nx = ST_BLOCKED;
            end else begin
              w_state_nx = ST_PIN_ENTRY;
            end
          end
        end
        ST_MENU: begin
          if (trans_stb) begin
            case (trans_type)
              TR_DEPOSIT:  w_state_nx = ST_DEPOSIT;
              TR_WITHDRAW: w_state_nx = ST_WITHDRAW;
              TR_INQUIRY:  w_state_nx = ST_INQUIRY;
              default:     w_state_nx = ST_DONE;
            endcase
          end
        end
        ST_DEPOSIT: begin
          if (amount_stb) begin
            if (w_dep_sum[BAL_W]) begin
              w_le_nx = 1'b1;
            end else begin
              w_bal_we    = 1'b1;
              w_bal_wdata = w_dep_sum[BAL_W-1:0];
              w_bu_nx     = 1'b1;
            end
            w_state_nx = ST_MENU;
          end
        end
        ST_WITHDRAW: begin
          if (amount_stb) begin
            if (w_short) begin
              w_if_nx = 1'b1;
            end else if (w_over_limit) begin
              w_le_nx = 1'b1;
            end else begin
              w_bal_we    = 1'b1;
              w_bal_wdata = w_sel_bal - w_amt_ext[BAL_W-1:0];
              w_sess_nx   = w_wd_total[BAL_W-1:0];
              w_gm_nx     = 1'b1;
              w_bu_nx     = 1'b1;
            end
            w_state_nx = ST_MENU;
          end
        end
        ST_INQUIRY: begin
          w_bal_out_nx = w_sel_bal;
          w_bv_nx      = 1'b1;
          w_state_nx   = ST_MENU;
        end
        ST_DONE: begin
          w_incorrect_nx = 1'b0;
          w_warning_nx   = 1'b0;
        end
        ST_BLOCKED: w_block_nx = 1'b1;
        default:    w_state_nx = ST_IDLE;
      endcase

      // A pending state change (PIN complete) wins over an expiring timer.
      if (w_tmo_hit && (w_state_nx == r_state)) begin
        w_to_nx    = 1'b1;
        w_state_nx = ST_DONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) r_bal[i] <= BAL_W'(INIT_BAL);
      r_blocked   <= '0;
      r_acct      <= '0;
      r_tries     <= '0;
      r_sess      <= '0;
      r_tmo       <= '0;
      r_incorrect <= 1'b0;
      r_warning   <= 1'b0;
      r_block     <= 1'b0;
      r_bu        <= 1'b0;
      r_gm        <= 1'b0;
      r_if        <= 1'b0;
      r_le        <= 1'b0;
      r_to        <= 1'b0;
      r_bv        <= 1'b0;
      r_bal_out   <= '0;
    end else begin
      if (w_bal_we)  r_bal[r_acct]     <= w_bal_wdata;
      if (w_set_blk) r_blocked[r_acct] <= 1'b1;
      r_acct      <= w_acct_nx;
      r_tries     <= w_tries_nx;
      r_sess      <= w_sess_nx;
      r_tmo       <= (!w_waiting || w_any_stb || (w_state_nx != r_state)) ? '0 : r_tmo + TMO_W'(1);
      r_incorrect <= w_incorrect_nx;
      r_warning   <= w_warning_nx;
      r_block     <= w_block_nx;
      r_bu        <= w_bu_nx;
      r_gm        <= w_gm_nx;
      r_if        <= w_if_nx;
      r_le        <= w_le_nx;
      r_to        <= w_to_nx;
      r_bv        <= w_bv_nx;
      r_bal_out   <= w_bal_out_nx;
    end
  end

  assign balance_updated    = r_bu;
  assign give_money         = r_gm;
  assign incorrect_pin      = r_incorrect;
  assign warning            = r_warning;
  assign block              = r_block;
  assign insufficient_funds = r_if;
  assign limit_exceeded     = r_le;
  assign timeout            = r_to;
  assign balance_out        = r_bal_out;
  assign balance_valid      = r_bv;

endmodule
